fp_unpack_pipe: RTL and testbench
=================================

FP_UNPACK_PIPE -- requirements
Module: fp_unpack_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MAN_W, default 23, stored fraction width; W = 1+EXP_W+MAN_W.
REQ-003 Parameter NORM_SUB, default 1: 1 = normalise subnormals, 0 = pass raw fraction with hidden bit 0.
REQ-004 clk  input  1  sole clock, all state on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operand present on fp_in.
REQ-007 in_ready  output  1  block accepts fp_in this cycle.
REQ-008 fp_in  input  W  IEEE 754 operand {sign, exponent, fraction}.
REQ-009 out_valid  output  1  result fields valid.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 sign  output  1  operand sign bit.
REQ-012 exponent  output  EXP_W+2  signed biased exponent after normalisation.
REQ-013 mantissa  output  MAN_W+1  significand including hidden bit.
REQ-014 fclass  output  10  one-hot class mask, RISC-V FCLASS bit order.
REQ-015 is_special, is_subnormal, is_zero, is_nan  output  1 each  classification flags.

Function
REQ-016 Two-stage pipeline: stage 1 registers operand plus classification; stage 2 registers leading-zero count result and shifted significand; latency exactly 2 cycles with no stall.
REQ-017 Transfer at input when in_valid && in_ready; at output when out_valid && out_ready.
REQ-018 Stage advance: s2 loads when !s2_valid || out_ready; s1 loads when !s1_valid || s2 loads; in_ready = s1 load condition (combinational, no combinational path from in_valid).
REQ-019 Full throughput: one result per cycle with out_ready held high.
REQ-020 While out_valid && !out_ready all outputs SHALL hold stable; no operand lost or duplicated under any back-pressure pattern.
REQ-021 fclass bits: 0 -inf, 1 -normal, 2 -subnormal, 3 -zero, 4 +zero, 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN (fraction MSB 0, fraction != 0), 9 qNaN (fraction MSB 1); exactly one bit set per valid result.
REQ-022 Normal: exponent = field zero-extended, mantissa = {1, fraction}.
REQ-023 Zero: exponent = 0, mantissa = 0, is_zero = 1.
REQ-024 Special (exp field all ones): exponent = field zero-extended, mantissa = {0, fraction}, is_special = 1, is_nan = (fraction != 0).
REQ-025 Subnormal, NORM_SUB=1: lz = leading zeros of fraction (MAN_W bits); mantissa = {1, (fraction << (lz+1)) truncated to MAN_W}; exponent = -lz (two's complement).
REQ-026 Subnormal, NORM_SUB=0: exponent = 0, mantissa = {0, fraction}.
REQ-027 is_subnormal reflects the input class, independent of NORM_SUB.
REQ-028 Flags and fclass SHALL be mutually consistent with REQ-021 for every input.

Reset
REQ-029 rst high on an edge clears s1_valid and s2_valid; out_valid = 0 and in_ready = 1 on the following cycle.
REQ-030 Reset values: all data outputs, fclass and flags = 0.
REQ-031 Reset mid-operation discards all in-flight operands; no result for them is ever presented.
REQ-032 Any input handshake coinciding with rst high is discarded.

Structure
REQ-033 Shared package fp_pkg holds: fclass bit-index constants, fp_class_t typedef, binary16/32/64 EXP_W/MAN_W constants.
REQ-034 One sub-module fp_lzc: parametrised combinational leading-zero counter (width MAN_W, output clog2(MAN_W+1) bits, all-zero input returns MAN_W).
REQ-035 No other sub-modules; stage registers live in fp_unpack_pipe.

Verification
REQ-036 Defaults, out_ready=1: 0x3F800000 -> after 2 cycles sign 0, exponent 127, mantissa 0x800000, fclass 0x040.
REQ-037 0x00000001 -> exponent -22, mantissa 0x800000, fclass 0x020, is_subnormal 1; 0x00400000 -> exponent 0, mantissa 0x800000.
REQ-038 0xFF800000 -> fclass 0x001, is_special 1; 0x7FC00000 -> fclass 0x200; 0x7F800001 -> fclass 0x100, is_nan 1; 0x80000000 -> fclass 0x008, exponent 0, mantissa 0.
REQ-039 Back-to-back 8 operands, out_ready low cycles 3-6: in_ready drops after 2 held results, outputs stable, all 8 results delivered in order, no duplicates.
REQ-040 rst asserted one cycle with 2 operands in flight -> out_valid 0 next cycle, neither result ever appears.
REQ-041 EXP_W=5, MAN_W=10, 0x0001 -> exponent -9, mantissa 0x400, fclass 0x020.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: class encoding, FCLASS bit positions
// and the field widths of the common IEEE 754 binary formats.
package fp_pkg;

  // FCLASS result vector width and bit positions (RISC-V order)
  localparam int FCLASS_W     = 10;
  localparam int FC_NEG_INF   = 0;
  localparam int FC_NEG_NORM  = 1;
  localparam int FC_NEG_SUB   = 2;
  localparam int FC_NEG_ZERO  = 3;
  localparam int FC_POS_ZERO  = 4;
  localparam int FC_POS_SUB   = 5;
  localparam int FC_POS_NORM  = 6;
  localparam int FC_POS_INF   = 7;
  localparam int FC_SNAN      = 8;
  localparam int FC_QNAN      = 9;

  // Operand class; each encoding equals its FCLASS bit index
  typedef enum logic [3:0] {
    CLS_NEG_INF    = 4'd0,
    CLS_NEG_NORMAL = 4'd1,
    CLS_NEG_SUB    = 4'd2,
    CLS_NEG_ZERO   = 4'd3,
    CLS_POS_ZERO   = 4'd4,
    CLS_POS_SUB    = 4'd5,
    CLS_POS_NORMAL = 4'd6,
    CLS_POS_INF    = 4'd7,
    CLS_SNAN       = 4'd8,
    CLS_QNAN       = 4'd9
  } fp_class_t;

  // IEEE 754 binary format field widths
  localparam int B16_EXP_W = 5;
  localparam int B16_MAN_W = 10;
  localparam int B32_EXP_W = 8;
  localparam int B32_MAN_W = 23;
  localparam int B64_EXP_W = 11;
  localparam int B64_MAN_W = 52;

  // One-hot FCLASS mask for a class (encoding doubles as the bit index)
  function automatic logic [FCLASS_W-1:0] class_onehot(input fp_class_t c);
    return {{(FCLASS_W-1){1'b0}}, 1'b1} << c;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module fp_lzc #(
  parameter int WIDTH = 23
) (
  input  logic [WIDTH-1:0]           value,
  output logic [$clog2(WIDTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(WIDTH+1);

  // Scan from LSB upward so the most significant set bit wins last
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) begin
        count = CNT_W'(WIDTH - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fp_unpack_pipe.sv
// Two-stage IEEE 754 operand unpacker: stage 1 registers the operand and its
// class, stage 2 registers the normalised exponent/significand and flags.
module fp_unpack_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W    = 8,
  parameter int MAN_W    = 23,
  parameter int NORM_SUB = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+MAN_W:0]  fp_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sign,
  output logic [EXP_W+1:0]      exponent,
  output logic [MAN_W:0]        mantissa,
  output logic [FCLASS_W-1:0]   fclass,
  output logic                  is_special,
  output logic                  is_subnormal,
  output logic                  is_zero,
  output logic                  is_nan
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int LZ_W = $clog2(MAN_W + 1);
  localparam int XW   = EXP_W + 2;

  // Stage 1 state
  logic              s1_valid_reg;
  logic              s1_sign_reg;
  logic [EXP_W-1:0]  s1_exp_reg;
  logic [MAN_W-1:0]  s1_frac_reg;
  fp_class_t         s1_class_reg;

  // Stage 2 state
  logic              s2_valid_reg;
  logic              s2_sign_reg;
  logic [XW-1:0]     s2_exp_reg;
  logic [MAN_W:0]    s2_man_reg;
  logic [FCLASS_W-1:0] s2_fclass_reg;
  logic              s2_special_reg;
  logic              s2_sub_reg;
  logic              s2_zero_reg;
  logic              s2_nan_reg;

  // Handshake / advance
  logic s1_load;
  logic s2_load;

  // Input field split and classification
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [MAN_W-1:0]  in_frac;
  fp_class_t         in_class_next;

  // Stage 2 datapath
  logic [LZ_W-1:0]   lz;
  logic [LZ_W:0]     lz_plus1;
  logic [MAN_W-1:0]  norm_frac;
  logic [XW-1:0]     s2_exp_next;
  logic [MAN_W:0]    s2_man_next;

  assign s2_load  = !s2_valid_reg || out_ready;
  assign s1_load  = !s1_valid_reg || s2_load;
  assign in_ready = s1_load;

  assign in_sign = fp_in[W-1];
  assign in_exp  = fp_in[W-2 -: EXP_W];
  assign in_frac = fp_in[MAN_W-1:0];

  // Classify the incoming operand from its exponent and fraction fields
  always_comb begin
    in_class_next = in_sign ? CLS_NEG_NORMAL : CLS_POS_NORMAL;
    if (&in_exp) begin
      if (in_frac == '0) begin
        in_class_next = in_sign ? CLS_NEG_INF : CLS_POS_INF;
      end else begin
        in_class_next = in_frac[MAN_W-1] ? CLS_QNAN : CLS_SNAN;
      end
    end else if (in_exp == '0) begin
      if (in_frac == '0) begin
        in_class_next = in_sign ? CLS_NEG_ZERO : CLS_POS_ZERO;
      end else begin
        in_class_next = in_sign ? CLS_NEG_SUB : CLS_POS_SUB;
      end
    end
  end

  // Stage 1 register: capture operand and class on each accepted transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_sign_reg  <= 1'b0;
      s1_exp_reg   <= '0;
      s1_frac_reg  <= '0;
      s1_class_reg <= CLS_NEG_INF;
    end else if (s1_load) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_sign_reg  <= in_sign;
        s1_exp_reg   <= in_exp;
        s1_frac_reg  <= in_frac;
        s1_class_reg <= in_class_next;
      end
    end
  end

  fp_lzc #(
    .WIDTH (MAN_W)
  ) u_lzc (
    .value (s1_frac_reg),
    .count (lz)
  );

  // A subnormal's leading one moves into the hidden-bit position
  assign lz_plus1  = (LZ_W+1)'(lz) + (LZ_W+1)'(1);
  assign norm_frac = s1_frac_reg << lz_plus1;

  // Build the unpacked exponent and significand for the stage 1 class
  always_comb begin
    s2_exp_next = '0;
    s2_man_next = '0;
    case (s1_class_reg)
      CLS_NEG_NORMAL, CLS_POS_NORMAL: begin
        s2_exp_next = {2'b00, s1_exp_reg};
        s2_man_next = {1'b1, s1_frac_reg};
      end
      CLS_NEG_INF, CLS_POS_INF, CLS_SNAN, CLS_QNAN: begin
        s2_exp_next = {2'b00, s1_exp_reg};
        s2_man_next = {1'b0, s1_frac_reg};
      end
      CLS_NEG_SUB, CLS_POS_SUB: begin
        if (NORM_SUB != 0) begin
          s2_exp_next = XW'(0) - XW'(lz);
          s2_man_next = {1'b1, norm_frac};
        end else begin
          s2_exp_next = '0;
          s2_man_next = {1'b0, s1_frac_reg};
        end
      end
      default: begin
        s2_exp_next = '0;
        s2_man_next = '0;
      end
    endcase
  end

  // Stage 2 register: results and flags, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg   <= 1'b0;
      s2_sign_reg    <= 1'b0;
      s2_exp_reg     <= '0;
      s2_man_reg     <= '0;
      s2_fclass_reg  <= '0;
      s2_special_reg <= 1'b0;
      s2_sub_reg     <= 1'b0;
      s2_zero_reg    <= 1'b0;
      s2_nan_reg     <= 1'b0;
    end else if (s2_load) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_sign_reg    <= s1_sign_reg;
        s2_exp_reg     <= s2_exp_next;
        s2_man_reg     <= s2_man_next;
        s2_fclass_reg  <= class_onehot(s1_class_reg);
        s2_special_reg <= (s1_class_reg == CLS_NEG_INF) || (s1_class_reg == CLS_POS_INF) ||
                          (s1_class_reg == CLS_SNAN)    || (s1_class_reg == CLS_QNAN);
        s2_sub_reg     <= (s1_class_reg == CLS_NEG_SUB)  || (s1_class_reg == CLS_POS_SUB);
        s2_zero_reg    <= (s1_class_reg == CLS_NEG_ZERO) || (s1_class_reg == CLS_POS_ZERO);
        s2_nan_reg     <= (s1_class_reg == CLS_SNAN)     || (s1_class_reg == CLS_QNAN);
      end
    end
  end

  assign out_valid    = s2_valid_reg;
  assign sign         = s2_sign_reg;
  assign exponent     = s2_exp_reg;
  assign mantissa     = s2_man_reg;
  assign fclass       = s2_fclass_reg;
  assign is_special   = s2_special_reg;
  assign is_subnormal = s2_sub_reg;
  assign is_zero      = s2_zero_reg;
  assign is_nan       = s2_nan_reg;

endmodule

// File: tb/tb_fp_unpack_pipe.sv
// Directed bench for fp_unpack_pipe: binary32 with and without subnormal
// normalisation, plus a binary16 instance.
module tb_fp_unpack_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared binary32 stimulus
  logic        rst;
  logic        in_valid;
  logic [31:0] fp_in;
  logic        out_ready;

  // Normalising instance outputs
  logic        in_ready, out_valid, sign;
  logic [9:0]  exponent;
  logic [23:0] mantissa;
  logic [9:0]  fclass;
  logic        is_special, is_subnormal, is_zero, is_nan;

  // Raw-subnormal instance outputs
  logic        r_in_ready, r_out_valid, r_sign;
  logic [9:0]  r_exponent;
  logic [23:0] r_mantissa;
  logic [9:0]  r_fclass;
  logic        r_is_special, r_is_subnormal, r_is_zero, r_is_nan;

  // binary16 instance
  logic        h_in_valid, h_out_ready;
  logic [15:0] h_fp_in;
  logic        h_in_ready, h_out_valid, h_sign;
  logic [6:0]  h_exponent;
  logic [10:0] h_mantissa;
  logic [9:0]  h_fclass;
  logic        h_is_special, h_is_subnormal, h_is_zero, h_is_nan;

  fp_unpack_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .fp_in(fp_in),
    .out_valid(out_valid), .out_ready(out_ready), .sign(sign), .exponent(exponent),
    .mantissa(mantissa), .fclass(fclass), .is_special(is_special),
    .is_subnormal(is_subnormal), .is_zero(is_zero), .is_nan(is_nan)
  );

  fp_unpack_pipe #(.NORM_SUB(0)) dut_raw (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r_in_ready), .fp_in(fp_in),
    .out_valid(r_out_valid), .out_ready(out_ready), .sign(r_sign), .exponent(r_exponent),
    .mantissa(r_mantissa), .fclass(r_fclass), .is_special(r_is_special),
    .is_subnormal(r_is_subnormal), .is_zero(r_is_zero), .is_nan(r_is_nan)
  );

  fp_unpack_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .fp_in(h_fp_in),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .sign(h_sign), .exponent(h_exponent),
    .mantissa(h_mantissa), .fclass(h_fclass), .is_special(h_is_special),
    .is_subnormal(h_is_subnormal), .is_zero(h_is_zero), .is_nan(h_is_nan)
  );

  logic [49:0] snap;
  assign snap = {out_valid, sign, exponent, mantissa, fclass,
                 is_special, is_subnormal, is_zero, is_nan};

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_cmp++;
    if (obs !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, req);
    end
  endtask

  // flg = {is_special, is_subnormal, is_zero, is_nan}
  typedef struct {
    logic [31:0] op;
    logic [9:0]  exp;
    logic [23:0] man;
    logic [9:0]  fc;
    logic [3:0]  flg;
  } vec_t;

  vec_t vecs[12];

  // Single operand through an idle pipeline, result checked 2 cycles later
  task automatic drive_one(input int idx, input vec_t v);
    logic [9:0]  raw_exp;
    logic [23:0] raw_man;
    @(negedge clk);
    in_valid = 1'b1;
    fp_in    = v.op;
    #1 check($sformatf("v%0d_in_ready", idx), in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    fp_in    = '0;
    @(negedge clk);
    #1;
    check($sformatf("v%0d_valid", idx), out_valid, 1);
    check($sformatf("v%0d_sign", idx), sign, v.op[31]);
    check($sformatf("v%0d_exp", idx), exponent, v.exp);
    check($sformatf("v%0d_man", idx), mantissa, v.man);
    check($sformatf("v%0d_fclass", idx), fclass, v.fc);
    check($sformatf("v%0d_flags", idx), {is_special, is_subnormal, is_zero, is_nan}, v.flg);
    raw_exp = v.flg[2] ? 10'h000 : v.exp;
    raw_man = v.flg[2] ? {1'b0, v.op[22:0]} : v.man;
    check($sformatf("v%0d_raw_exp", idx), r_exponent, raw_exp);
    check($sformatf("v%0d_raw_man", idx), r_mantissa, raw_man);
    check($sformatf("v%0d_raw_fc_flags", idx),
          {r_fclass, r_is_special, r_is_subnormal, r_is_zero, r_is_nan}, {v.fc, v.flg});
  endtask

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation bound reached, got no finish, want finish");
    $fatal(1);
  end

  initial begin
    int         exp_q[$];
    int         got;
    int         sent;
    int         idx;
    logic       held;
    logic       saw_block;
    logic       seen;
    logic [49:0] held_val;

    vecs[0]  = '{32'h3F800000, 10'h07F, 24'h800000, 10'h040, 4'b0000};
    vecs[1]  = '{32'h00000001, 10'h3EA, 24'h800000, 10'h020, 4'b0100};
    vecs[2]  = '{32'h00400000, 10'h000, 24'h800000, 10'h020, 4'b0100};
    vecs[3]  = '{32'hFF800000, 10'h0FF, 24'h000000, 10'h001, 4'b1000};
    vecs[4]  = '{32'h7FC00000, 10'h0FF, 24'h400000, 10'h200, 4'b1001};
    vecs[5]  = '{32'h7F800001, 10'h0FF, 24'h000001, 10'h100, 4'b1001};
    vecs[6]  = '{32'h80000000, 10'h000, 24'h000000, 10'h008, 4'b0010};
    vecs[7]  = '{32'h00000000, 10'h000, 24'h000000, 10'h010, 4'b0010};
    vecs[8]  = '{32'hBF800000, 10'h07F, 24'h800000, 10'h002, 4'b0000};
    vecs[9]  = '{32'h80000003, 10'h3EB, 24'hC00000, 10'h004, 4'b0100};
    vecs[10] = '{32'h7F800000, 10'h0FF, 24'h000000, 10'h080, 4'b1000};
    vecs[11] = '{32'h40490FDB, 10'h080, 24'hC90FDB, 10'h040, 4'b0000};

    rst         = 1'b1;
    in_valid    = 1'b0;
    fp_in       = '0;
    out_ready   = 1'b1;
    h_in_valid  = 1'b0;
    h_fp_in     = '0;
    h_out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_data", {sign, exponent, mantissa}, 0);
    check("reset_fclass_flags", {fclass, is_special, is_subnormal, is_zero, is_nan}, 0);
    rst = 1'b0;

    // Directed single operands
    for (int i = 0; i < 12; i++) begin
      drive_one(i, vecs[i]);
    end

    // Back-to-back stream of 8 with the consumer stalled on cycles 3..6
    got = 0; sent = 0; held = 1'b0; saw_block = 1'b0; held_val = '0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 6);
      if (sent < 8) begin
        in_valid = 1'b1;
        fp_in    = vecs[sent].op;
      end else begin
        in_valid = 1'b0;
        fp_in    = '0;
      end
      #1;
      if (held) check($sformatf("stall_hold_c%0d", cyc), snap, held_val);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_extra_result", 1, 0);
        end else begin
          idx = exp_q.pop_front();
          check($sformatf("stream%0d_fields", got), {sign, exponent, mantissa, fclass},
                {vecs[idx].op[31], vecs[idx].exp, vecs[idx].man, vecs[idx].fc});
        end
        got++;
      end
      held     = out_valid && !out_ready;
      held_val = snap;
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (in_valid && in_ready) begin
        exp_q.push_back(sent);
        sent++;
      end
    end
    check("stream_count", got, 8);
    check("stream_in_ready_drop", saw_block, 1);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    fp_in     = '0;
    repeat (2) @(negedge clk);
    #1 check("stream_no_duplicate", out_valid, 0);

    // Reset with two operands in flight and a coinciding input handshake
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    fp_in     = vecs[0].op;
    @(negedge clk);
    fp_in = vecs[1].op;
    @(negedge clk);
    #1 check("rst_inflight_valid", out_valid, 1);
    rst       = 1'b1;
    out_ready = 1'b1;
    fp_in     = vecs[8].op;
    @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_clears_fields", {exponent, mantissa, fclass}, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    fp_in    = '0;
    seen     = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1 if (out_valid) seen = 1'b1;
    end
    check("rst_no_ghost_result", seen, 0);

    // binary16 instance: smallest subnormal, then 1.0
    @(negedge clk);
    h_in_valid = 1'b1;
    h_fp_in    = 16'h0001;
    @(negedge clk);
    h_fp_in = 16'h3C00;
    @(negedge clk);
    h_in_valid = 1'b0;
    h_fp_in    = '0;
    #1;
    check("h_sub_valid", h_out_valid, 1);
    check("h_sub_exp", h_exponent, 7'h77);
    check("h_sub_man", h_mantissa, 11'h400);
    check("h_sub_fclass", {h_fclass, h_is_subnormal}, {10'h020, 1'b1});
    @(negedge clk);
    #1;
    check("h_one_valid", h_out_valid, 1);
    check("h_one_exp", h_exponent, 7'h0F);
    check("h_one_man", h_mantissa, 11'h400);
    check("h_one_fclass", h_fclass, 10'h040);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
